// File: rtl/retro_memory_arbiter_if.sv
// Requester and memory bus bundle for the retro memory arbiter.
// master is the arbiter side, slave is the requester/memory side.
interface retro_memory_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic [2:0]          ReqValid;
  logic [2:0]          ReqWrite;
  logic [3*ADDR_W-1:0] ReqAddr;
  logic [3*DATA_W-1:0] ReqWData;
  logic [2:0]          ReqAck;
  logic [DATA_W-1:0]   RData;
  logic                Delay;
  logic                MemValid;
  logic                MemWrite;
  logic [ADDR_W-1:0]   MemAddr;
  logic [DATA_W-1:0]   MemWData;
  logic                MemReady;
  logic                MemDone;
  logic [DATA_W-1:0]   MemRData;
  logic                Error;

  modport master (
    input  ReqValid, ReqWrite, ReqAddr, ReqWData,
    input  MemReady, MemDone, MemRData,
    output ReqAck, RData, Delay, Error,
    output MemValid, MemWrite, MemAddr, MemWData
  );

  modport slave (
    output ReqValid, ReqWrite, ReqAddr, ReqWData,
    output MemReady, MemDone, MemRData,
    input  ReqAck, RData, Delay, Error,
    input  MemValid, MemWrite, MemAddr, MemWData
  );
endinterface

// File: rtl/retro_memory_arbiter.sv
// Three-way round-robin arbiter onto a single-outstanding memory port.
// A grant spends one cycle latching fields before ISSUE drives the bus.
module retro_memory_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input logic Clk,
  input logic Reset,
  retro_memory_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t            state;
  logic              armed;
  logic [1:0]        last;
  logic [1:0]        grant;
  logic [1:0]        sel;
  logic [1:0]        c0, c1, c2;
  logic              hit;
  logic [7:0]        cnt;
  logic [2:0]        ack;
  logic [DATA_W-1:0] rdata;
  logic              mvalid;
  logic              mwrite;
  logic [ADDR_W-1:0] maddr;
  logic [DATA_W-1:0] mwdata;
  logic              error;
  logic              gwrite;
  logic [ADDR_W-1:0] gaddr;
  logic [DATA_W-1:0] gdata;
  logic              tmo;
  logic              fin;

  // Search order starts just after the last winner.
  always_comb begin
    c0 = 2'd0;
    c1 = 2'd1;
    c2 = 2'd2;
    unique case (last)
      2'd0: begin
        c0 = 2'd1;
        c1 = 2'd2;
        c2 = 2'd0;
      end
      2'd1: begin
        c0 = 2'd2;
        c1 = 2'd0;
        c2 = 2'd1;
      end
      default: ;
    endcase
    hit = |bus.ReqValid;
    if (bus.ReqValid[c0])
      sel = c0;
    else if (bus.ReqValid[c1])
      sel = c1;
    else
      sel = c2;
  end

  always_comb begin
    gwrite = bus.ReqWrite[sel];
    unique case (sel)
      2'd1: begin
        gaddr = bus.ReqAddr[ADDR_W +: ADDR_W];
        gdata = bus.ReqWData[DATA_W +: DATA_W];
      end
      2'd2: begin
        gaddr = bus.ReqAddr[2*ADDR_W +: ADDR_W];
        gdata = bus.ReqWData[2*DATA_W +: DATA_W];
      end
      default: begin
        gaddr = bus.ReqAddr[0 +: ADDR_W];
        gdata = bus.ReqWData[0 +: DATA_W];
      end
    endcase
  end

  assign tmo = (state == WAIT) && !bus.MemDone
            && (cnt == 8'(TIMEOUT - 1));

  assign fin = (state == ISSUE && bus.MemReady && bus.MemDone)
            || (state == WAIT && bus.MemDone)
            || tmo;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      armed  <= 1'b0;
      last   <= 2'd2;
      grant  <= 2'd0;
      cnt    <= '0;
      ack    <= '0;
      rdata  <= '0;
      mvalid <= 1'b0;
      mwrite <= 1'b0;
      maddr  <= '0;
      mwdata <= '0;
      error  <= 1'b0;
    end else begin
      ack <= '0;
      if (fin) begin
        ack    <= 3'b001 << grant;
        mvalid <= 1'b0;
        state  <= IDLE;
        if (tmo) begin
          rdata <= '0;
          error <= 1'b1;
        end else if (!mwrite) begin
          rdata <= bus.MemRData;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (armed) begin
              armed  <= 1'b0;
              mvalid <= 1'b1;
              cnt    <= '0;
              state  <= ISSUE;
            end else if (hit) begin
              armed  <= 1'b1;
              grant  <= sel;
              last   <= sel;
              mwrite <= gwrite;
              maddr  <= gaddr;
              mwdata <= gdata;
            end
          end
          ISSUE: begin
            if (bus.MemReady) begin
              mvalid <= 1'b0;
              state  <= WAIT;
            end
          end
          WAIT: cnt <= cnt + 8'd1;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.ReqAck   = ack;
  assign bus.RData    = rdata;
  assign bus.Delay    = |(bus.ReqValid & ~ack);
  assign bus.MemValid = mvalid;
  assign bus.MemWrite = mwrite;
  assign bus.MemAddr  = maddr;
  assign bus.MemWData = mwdata;
  assign bus.Error    = error;

endmodule

// File: tb/tb_retro_memory_arbiter.sv
// Scoreboard bench for retro_memory_arbiter.
// Expected acks are queued at request time and popped on ReqAck.
module tb_retro_memory_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  retro_memory_arbiter_if #(.ADDR_W(24), .DATA_W(16)) bus ();

  retro_memory_arbiter #(
    .ADDR_W (24),
    .DATA_W (16),
    .TIMEOUT(255)
  ) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus.master)
  );

  typedef struct packed {
    logic [2:0]  ack;
    logic [15:0] rd;
  } exp_t;

  exp_t sb[$];
  int   npass = 0;
  int   ntot  = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    ntot++;
    if (got === exp)
      npass++;
    else
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic push(logic [2:0] a, logic [15:0] d);
    exp_t e;
    e.ack = a;
    e.rd  = d;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.ReqAck != 3'b000) begin
      chk("ack_onehot", 64'($countones(bus.ReqAck)), 64'd1);
      if (sb.size() == 0) begin
        chk("ack_unexp", 64'(bus.ReqAck), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_who", 64'(bus.ReqAck), 64'(e.ack));
        chk("ack_rdata", 64'(bus.RData), 64'(e.rd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    int lat;
    bit seen;
    bus.ReqValid = '0;
    bus.ReqWrite = '0;
    bus.ReqAddr  = '0;
    bus.ReqWData = '0;
    bus.MemReady = 1'b0;
    bus.MemDone  = 1'b0;
    bus.MemRData = '0;

    rst = 1'b1;
    repeat (2) tick();
    chk("rst_ack", 64'(bus.ReqAck), 64'd0);
    chk("rst_mvalid", 64'(bus.MemValid), 64'd0);
    chk("rst_mwrite", 64'(bus.MemWrite), 64'd0);
    chk("rst_maddr", 64'(bus.MemAddr), 64'd0);
    chk("rst_mwdata", 64'(bus.MemWData), 64'd0);
    chk("rst_rdata", 64'(bus.RData), 64'd0);
    chk("rst_error", 64'(bus.Error), 64'd0);
    chk("rst_delay", 64'(bus.Delay), 64'd0);
    rst = 1'b0;
    tick();

    // round robin from reset: 0,1,2,0
    bus.ReqAddr  = {24'h000003, 24'h000002, 24'h000001};
    bus.MemReady = 1'b1;
    bus.MemDone  = 1'b1;
    bus.MemRData = 16'h0A0A;
    push(3'b001, 16'h0A0A);
    push(3'b010, 16'h0A0A);
    push(3'b100, 16'h0A0A);
    push(3'b001, 16'h0A0A);
    bus.ReqValid = 3'b111;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      tick();
      if (bus.ReqAck != 3'b000) n++;
    end
    bus.ReqValid = '0;
    chk("rr_count", 64'(n), 64'd4);
    tick();

    // single read, minimum latency
    bus.ReqAddr[23:0] = 24'h000100;
    bus.MemRData = 16'hBEEF;
    push(3'b001, 16'hBEEF);
    bus.ReqValid = 3'b001;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      lat++;
      if (lat == 2)
        chk("rd_issue", 64'({bus.MemValid, bus.MemAddr}),
            64'({1'b1, 24'h000100}));
      if (bus.ReqAck != 3'b000) break;
    end
    bus.ReqValid = '0;
    chk("rd_lat", 64'(lat), 64'd3);
    chk("rd_rdata", 64'(bus.RData), 64'hBEEF);
    tick();

    // write from requester 2 with late MemReady
    bus.MemReady = 1'b0;
    bus.MemDone  = 1'b0;
    bus.ReqAddr[71:48]  = 24'h123456;
    bus.ReqWData[47:32] = 16'h5A5A;
    bus.ReqWrite = 3'b100;
    push(3'b100, 16'hBEEF);
    bus.ReqValid = 3'b100;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.MemValid) break;
    end
    chk("wr_issue", 64'(bus.MemValid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) tick();
      chk("wr_hold",
          64'({bus.MemValid, bus.MemWrite, bus.MemAddr, bus.MemWData}),
          64'({1'b1, 1'b1, 24'h123456, 16'h5A5A}));
    end
    bus.MemReady = 1'b1;
    bus.MemDone  = 1'b1;
    tick();
    chk("wr_ack", 64'(bus.ReqAck), 64'b100);
    chk("wr_rdata", 64'(bus.RData), 64'hBEEF);
    bus.ReqValid = '0;
    bus.ReqWrite = '0;
    tick();

    // request dropped after one cycle still completes
    bus.ReqAddr[23:0] = 24'h000400;
    bus.MemRData = 16'h1234;
    push(3'b001, 16'h1234);
    bus.ReqValid = 3'b001;
    tick();
    bus.ReqValid = '0;
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      lat++;
      if (bus.ReqAck != 3'b000) break;
    end
    chk("drop_lat", 64'(lat), 64'd3);
    tick();

    // Delay follows pending request until its ack
    chk("dly_idle", 64'(bus.Delay), 64'd0);
    bus.MemRData = 16'h7777;
    push(3'b010, 16'h7777);
    bus.ReqValid = 3'b010;
    #1;
    chk("dly_req", 64'(bus.Delay), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.ReqAck != 3'b000) begin
        seen = 1'b1;
        chk("dly_ack", 64'(bus.Delay), 64'd0);
        break;
      end
      chk("dly_pend", 64'(bus.Delay), 64'd1);
    end
    chk("dly_seen", 64'(seen), 64'd1);
    bus.ReqValid = '0;
    tick();

    // timeout: MemDone never arrives
    bus.MemReady = 1'b1;
    bus.MemDone  = 1'b0;
    bus.ReqAddr[23:0] = 24'h000200;
    push(3'b001, 16'h0000);
    bus.ReqValid = 3'b001;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.MemValid) break;
    end
    tick();
    chk("to_wait", 64'(bus.MemValid), 64'd0);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      n++;
      if (bus.ReqAck != 3'b000) break;
    end
    chk("to_lat", 64'(n), 64'd255);
    chk("to_err", 64'(bus.Error), 64'd1);
    chk("to_rdata", 64'(bus.RData), 64'd0);
    bus.ReqValid = '0;
    repeat (5) tick();
    chk("to_sticky", 64'(bus.Error), 64'd1);

    // reset while in WAIT, then a stray MemDone
    bus.ReqValid = 3'b010;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.MemValid) break;
    end
    repeat (4) tick();
    rst = 1'b1;
    bus.ReqValid = '0;
    tick();
    rst = 1'b0;
    chk("wr_rst_all",
        64'({bus.ReqAck, bus.MemValid, bus.MemWrite,
             bus.MemAddr, bus.MemWData, bus.RData, bus.Error}),
        64'd0);
    bus.MemDone = 1'b1;
    tick();
    bus.MemDone = 1'b0;
    repeat (5) tick();
    chk("wr_rst_idle", 64'(bus.MemValid), 64'd0);

    // priority restarts at requester 0 after reset
    bus.MemReady = 1'b1;
    bus.MemDone  = 1'b1;
    bus.MemRData = 16'h4444;
    push(3'b001, 16'h4444);
    bus.ReqValid = 3'b011;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.ReqAck != 3'b000) begin
        seen = 1'b1;
        break;
      end
    end
    bus.ReqValid = '0;
    chk("post_rst_ack", 64'(seen), 64'd1);
    repeat (3) tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/retro_memory_arbiter.md
RETRO_MEMORY_ARBITER -- requirements
Module: retro_memory_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_W, 24, address width
- DATA_W, 16, data width
- TIMEOUT, 255, maximum WAIT cycles before forced completion (1..255)
REQ-002 Ports (name, direction, width, meaning), one per line:
- Clk, in, 1, core clock; one clock only
- Reset, in, 1, synchronous, active-high reset
- ReqValid, in, 3, per-requester request (0 = core MainRAM, 1 = core VRAM, 2 = cartridge controller)
- ReqWrite, in, 3, per-requester write (1) or read (0)
- ReqAddr, in, 3*ADDR_W, requester i at [i*ADDR_W +: ADDR_W]
- ReqWData, in, 3*DATA_W, requester i at [i*DATA_W +: DATA_W]
- ReqAck, out, 3, one-cycle completion pulse per requester
- RData, out, DATA_W, read data, valid with ReqAck
- Delay, out, 1, CATC stall request
- MemValid, out, 1, downstream request
- MemWrite, out, 1, downstream write
- MemAddr, out, ADDR_W, downstream address
- MemWData, out, DATA_W, downstream write data
- MemReady, in, 1, downstream accepts request
- MemDone, in, 1, downstream completion
- MemRData, in, DATA_W, downstream read data, valid with MemDone
- Error, out, 1, sticky timeout flag

Function
REQ-003 The block SHALL run a single-outstanding-transaction FSM with states IDLE, ISSUE and WAIT.
REQ-004 In IDLE with any ReqValid set, the block SHALL grant the first set requester, searching round-robin from (LastGrant+1) mod 3.
REQ-005 On grant, the block SHALL register the granted write, address and data, update LastGrant, and enter ISSUE on the next cycle.
REQ-006 In ISSUE, MemValid SHALL be 1 and the Mem* fields SHALL hold the latched values and stay stable until MemReady.
REQ-007 In ISSUE with MemReady=1 and MemDone=0, the FSM SHALL enter WAIT and drive MemValid=0.
REQ-008 In ISSUE with MemReady=1 and MemDone=1, the block SHALL complete immediately per REQ-009.
REQ-009 On completion, the block SHALL:
- pulse ReqAck[grant] for exactly one cycle on the next edge
- register RData from MemRData (reads), or leave RData unchanged (writes)
- return to IDLE
REQ-010 The minimum latency from ReqValid rising to ReqAck, with MemReady and MemDone tied high, SHALL be 3 cycles.
REQ-011 A requester SHALL hold ReqValid and its fields stable until ReqAck; ReqValid still high in the cycle after ReqAck SHALL be treated as a new request.
REQ-012 A ReqValid dropped before ReqAck SHALL NOT cancel a granted transaction; completion still pulses ReqAck.
REQ-013 In WAIT, an 8-bit counter SHALL increment each cycle without MemDone.
REQ-014 If the WAIT counter reaches TIMEOUT, the block SHALL:
- force completion per REQ-009 with RData=0
- set Error=1, which stays set until Reset
REQ-015 The WAIT counter SHALL clear on entry to ISSUE.
REQ-016 MemDone or MemReady arriving in IDLE SHALL be ignored.
REQ-017 Delay SHALL be combinational: |(ReqValid & ~ReqAck).
REQ-018 At most one ReqAck bit SHALL be set in any cycle.

Reset
REQ-019 While Reset=1 at a clock edge, the block SHALL enter IDLE and set:
- LastGrant=2, so requester 0 has first priority
- ReqAck=0, MemValid=0, MemWrite=0, MemAddr=0, MemWData=0
- RData=0, Error=0, counter=0
REQ-020 Reset mid-transaction SHALL abandon the transaction with no ReqAck, and any later MemDone SHALL be ignored.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- ReqValid=001, read 0x000100, MemReady=MemDone=1, MemRData=0xBEEF -> ReqAck=001 three cycles after request, RData=0xBEEF.
- ReqValid=111 held, immediate memory -> grants in order 0,1,2,0, and no requester is granted twice before the others.
- Write from requester 2, addr 0x123456, data 0x5A5A, MemReady delayed 4 cycles -> MemValid high and Mem* stable for 4 cycles, then ReqAck=100, RData unchanged.
- MemDone never asserted, TIMEOUT=255 -> ReqAck after 255 WAIT cycles, RData=0, Error=1 until Reset.
- Reset asserted while in WAIT, then MemDone pulsed -> no ReqAck, IDLE, all outputs at reset values.
- Delay check: ReqValid=010 pending -> Delay=1 each cycle until the ReqAck cycle, where Delay=0.
